// File: rtl/fifo_umbral_pkg.sv
// fifo_umbral_pkg
// Shared constants and types for the per-virtual-channel FIFO with
// programmable almost-full / almost-empty thresholds ("umbrales").
// Holds the default geometry, the reset thresholds and the occupancy
// type that the QoS flow-control FSM also uses on its threshold ports.
package fifo_umbral_pkg;

  localparam int DATA_WIDTH_DEF    = 6;
  localparam int ADDR_WIDTH_DEF    = 3;
  localparam int UMBRAL_AF_RST_DEF = 6;
  localparam int UMBRAL_AE_RST_DEF = 1;

  // Occupancy needs one extra bit so that a completely full FIFO
  // (DEPTH words) is distinguishable from an empty one.
  typedef logic [ADDR_WIDTH_DEF:0] count_t;

endpackage

// File: rtl/fifo_umbral_if.sv
// fifo_umbral_if
// Bundles the FIFO's handshake, data and status signals.
//   master : upstream/FSM side, drives init, thresholds, push, data_in, pop
//            and observes data/status.
//   slave  : the FIFO itself.
// Signals:
//   init, umbral_af, umbral_ae : threshold programming
//   push, data_in              : write side
//   pop, data_out, valid_out   : read side (data_out registered)
//   fifo_empty, fifo_full, almost_full, almost_empty, fifo_error, count
interface fifo_umbral_if
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  init;
  logic [ADDR_WIDTH:0]   umbral_af;
  logic [ADDR_WIDTH:0]   umbral_ae;
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_error;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output init, umbral_af, umbral_ae, push, data_in, pop,
    input  data_out, valid_out, fifo_empty, fifo_full,
           almost_full, almost_empty, fifo_error, count
  );

  modport slave (
    input  init, umbral_af, umbral_ae, push, data_in, pop,
    output data_out, valid_out, fifo_empty, fifo_full,
           almost_full, almost_empty, fifo_error, count
  );

endinterface

// File: rtl/fifo_umbral_ram_2p.sv
// ram_2p
// DEPTH x DATA_WIDTH storage with one synchronous write port and one
// registered read port. The read register is the FIFO's data_out and
// holds its value when no read is requested.
// Ports:
//   clk, reset          : clock, async active-high reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i       : read request/address
//   rdata_o             : registered read data
module ram_2p #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array is deliberately left without reset; the FIFO pointers
  // define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register samples the old contents when read and write hit the
  // same slot, which is what a full FIFO doing push+pop needs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_umbral.sv
// fifo_umbral
// Per-virtual-channel packet buffer feeding the QoS flow-control FSM.
// Produces empty/full, almost-full/almost-empty (against thresholds
// latched while init is high) and a sticky overflow/underflow flag.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : fifo_umbral_if.slave (handshake, data and status)
// Optional feature:
//   FIFO_UMBRAL_ERR_CLR_EN - when defined, an edge with init high also
//   clears fifo_error (a new overflow/underflow on that edge wins).
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int UMBRAL_AF_RST = UMBRAL_AF_RST_DEF,
  parameter int UMBRAL_AE_RST = UMBRAL_AE_RST_DEF
) (
  input logic         clk,
  input logic         reset,
  fifo_umbral_if.slave bus
);

  localparam int              CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0]   AF_RST  = CW'(UMBRAL_AF_RST);
  localparam logic [CW-1:0]   AE_RST  = CW'(UMBRAL_AE_RST);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         af_q, af_d;
  logic [CW-1:0]         ae_q, ae_d;
  logic                  error_q, error_d;
  logic                  valid_q;

  logic isEmpty, isFull, wrEn, rdEn, errEvent;

  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == DEPTH_C);

  // A pop on a full FIFO frees its slot on the same edge, so the push
  // still fits. Pop on empty never reads; there is no write-through.
  assign rdEn     = bus.pop && !isEmpty;
  assign wrEn     = bus.push && (!isFull || bus.pop);
  assign errEvent = (bus.push && isFull && !bus.pop) || (bus.pop && isEmpty);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    af_d    = af_q;
    ae_d    = ae_q;
    error_d = error_q;
    if (wrEn) begin
      wptr_d = wptr_q + ADDR_WIDTH'(1);
    end
    if (rdEn) begin
      rptr_d = rptr_q + ADDR_WIDTH'(1);
    end
    count_d = count_q + CW'(wrEn) - CW'(rdEn);
    if (bus.init) begin
      af_d = bus.umbral_af;
      ae_d = bus.umbral_ae;
    end
`ifdef FIFO_UMBRAL_ERR_CLR_EN
    if (bus.init) begin
      error_d = 1'b0;
    end
`endif
    if (errEvent) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      af_q    <= AF_RST;
      ae_q    <= AE_RST;
      error_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      error_q <= error_d;
      valid_q <= rdEn;
    end
  end

  ram_2p #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we_i   (wrEn),
    .waddr_i(wptr_q),
    .wdata_i(bus.data_in),
    .re_i   (rdEn),
    .raddr_i(rptr_q),
    .rdata_o(bus.data_out)
  );

  // A threshold above DEPTH simply never matches almost_full.
  assign bus.valid_out    = valid_q;
  assign bus.fifo_empty   = isEmpty;
  assign bus.fifo_full    = isFull;
  assign bus.almost_full  = (count_q >= af_q);
  assign bus.almost_empty = (count_q <= ae_q);
  assign bus.fifo_error   = error_q;
  assign bus.count        = count_q;

endmodule
